// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the request-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_bridge_state_t;

  localparam int TIMEOUT_CNT_WIDTH = 16;

endpackage

// File: rtl/apb_bridge_timer.sv
// ACCESS-phase watchdog; flags the last allowed ACCESS cycle of a transfer.
module apb_bridge_timer
  import apb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_CNT_WIDTH-1:0] LAST = TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt <= '0;
    end else if (count_i) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of ACCESS cycles already completed.
  assign expired_o = count_i && (cnt == LAST);

endmodule

// File: rtl/apb_req_bridge.sv
// Single-outstanding req/gnt to APB master bridge.
// Optional ACCESS timeout enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_req_bridge
  import apb_bridge_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH = 32,
  parameter int          APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
    $error("apb_req_bridge: TIMEOUT_CYCLES must be within 1..65535");
  end

  apb_bridge_state_t state, state_next;
  logic capture;
  logic done;
  logic timeout;
  logic timeout_hit;

`ifdef APB_BRIDGE_TIMEOUT_EN
  apb_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (capture),
    .count_i  (state == ACCESS),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    gnt_o      = 1'b0;
    psel_o     = 1'b0;
    penable_o  = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          capture    = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        psel_o     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        // A slave answering on the limit cycle still completes normally.
        if (pready_i) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        paddr_o  <= addr_i;
        pwrite_o <= we_i;
        pwdata_o <= wdata_i;
      end
      rvalid_o <= done | timeout;
      if (done) begin
        rdata_o <= pwrite_o ? '0 : prdata_i;
        err_o   <= pslverr_i;
      end else if (timeout) begin
        rdata_o <= '0;
        err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed self-checking bench for apb_req_bridge.
module tb_apb_req_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  apb_req_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .addr_i   (addr),
    .we_i     (we),
    .wdata_i  (wdata),
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .psel_o   (psel),
    .penable_o(penable),
    .pwrite_o (pwrite),
    .paddr_o  (paddr),
    .pwdata_o (pwdata),
    .prdata_i (prdata),
    .pready_i (pready),
    .pslverr_i(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Advance into the next cycle; inputs are driven here, checks follow after settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    settle();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();
    check("idle_gnt_noreq", gnt, 0);

    // Zero-wait read
    tick();
    req = 1'b1; addr = 32'h1A10_0000; we = 1'b0; pready = 1'b1; prdata = 32'hDEAD_BEEF;
    settle();
    check("rd_c0_gnt", gnt, 1);
    check("rd_c0_psel", psel, 0);
    tick(); req = 1'b0; settle();
    check("rd_c1_gnt", gnt, 0);
    check("rd_c1_psel", psel, 1);
    check("rd_c1_penable", penable, 0);
    check("rd_c1_paddr", paddr, 32'h1A10_0000);
    check("rd_c1_pwrite", pwrite, 0);
    tick(); settle();
    check("rd_c2_psel", psel, 1);
    check("rd_c2_penable", penable, 1);
    check("rd_c2_rvalid", rvalid, 0);
    tick(); settle();
    check("rd_c3_rvalid", rvalid, 1);
    check("rd_c3_rdata", rdata, 32'hDEAD_BEEF);
    check("rd_c3_err", err, 0);
    check("rd_c3_psel", psel, 0);
    tick(); prdata = 32'h0; settle();
    check("rd_c4_rvalid", rvalid, 0);
    check("rd_c4_rdata_hold", rdata, 32'hDEAD_BEEF);

    // Wait-state write: 4 ACCESS cycles with pready low, then ready
    tick();
    req = 1'b1; addr = 32'h1A10_0004; we = 1'b1; wdata = 32'h1234_5678;
    pready = 1'b0; prdata = 32'hCAFE_F00D;
    settle();
    check("wr_c0_gnt", gnt, 1);
    tick(); addr = 32'h0; wdata = 32'h0; we = 1'b0; settle();
    check("wr_c1_psel", psel, 1);
    check("wr_c1_penable", penable, 0);
    check("wr_c1_gnt_ignored", gnt, 0);
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 6) begin
        pready = 1'b1;
        req = 1'b0;
      end
      settle();
      check("wr_acc_penable", penable, 1);
      check("wr_acc_paddr", paddr, 32'h1A10_0004);
      check("wr_acc_pwdata", pwdata, 32'h1234_5678);
      check("wr_acc_pwrite", pwrite, 1);
      check("wr_acc_rvalid", rvalid, 0);
      check("wr_acc_gnt", gnt, 0);
    end
    tick(); settle();
    check("wr_c7_rvalid", rvalid, 1);
    check("wr_c7_rdata", rdata, 0);
    check("wr_c7_err", err, 0);
    check("wr_c7_paddr_hold", paddr, 32'h1A10_0004);
    tick(); settle();
    check("wr_c8_rvalid", rvalid, 0);

    // Slave error, then a clean transfer
    tick();
    req = 1'b1; addr = 32'h1A10_0008; we = 1'b0; pready = 1'b1; pslverr = 1'b1;
    prdata = 32'h55AA_55AA;
    settle();
    check("se_c0_gnt", gnt, 1);
    tick(); req = 1'b0; settle();
    tick(); settle();
    tick(); pslverr = 1'b0; settle();
    check("se_c3_rvalid", rvalid, 1);
    check("se_c3_err", err, 1);
    check("se_c3_rdata", rdata, 32'h55AA_55AA);
    tick(); settle();
    check("se_c4_err_hold", err, 1);
    tick();
    req = 1'b1; addr = 32'h1A10_000C; prdata = 32'h0000_0042;
    settle();
    tick(); req = 1'b0; settle();
    tick(); settle();
    tick(); settle();
    check("ok_c3_rvalid", rvalid, 1);
    check("ok_c3_err", err, 0);
    check("ok_c3_rdata", rdata, 32'h0000_0042);

    // Back-to-back: req held high for three requests
    tick();
    req = 1'b1; we = 1'b0; pready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr = 32'h1A10_0100 + 32'(4 * k);
      settle();
      check("b2b_gnt", gnt, 1);
      if (k > 0) begin
        check("b2b_rvalid", rvalid, 1);
        check("b2b_rdata", rdata, 32'h1000_0000 + 32'(k - 1));
      end
      tick();
      if (k == 2) req = 1'b0;
      settle();
      check("b2b_setup_gnt", gnt, 0);
      check("b2b_setup_penable", penable, 0);
      check("b2b_setup_paddr", paddr, 32'h1A10_0100 + 32'(4 * k));
      tick();
      prdata = 32'h1000_0000 + 32'(k);
      settle();
      check("b2b_access_penable", penable, 1);
      check("b2b_access_rvalid", rvalid, 0);
      tick();
    end
    settle();
    check("b2b_c9_rvalid", rvalid, 1);
    check("b2b_c9_rdata", rdata, 32'h1000_0002);
    check("b2b_c9_gnt", gnt, 0);

    // Reset during ACCESS
    tick();
    req = 1'b1; addr = 32'h1A10_0200; pready = 1'b0;
    settle();
    tick(); req = 1'b0; settle();
    tick(); rst = 1'b1; settle();
    check("rm_c2_penable", penable, 1);
    tick(); rst = 1'b0; settle();
    check("rm_c3_psel", psel, 0);
    check("rm_c3_penable", penable, 0);
    check("rm_c3_rvalid", rvalid, 0);
    check("rm_c3_paddr", paddr, 0);
    tick(); settle();
    check("rm_c4_rvalid", rvalid, 0);
    tick();
    req = 1'b1; addr = 32'h1A10_0300; pready = 1'b1; prdata = 32'hA5A5_0001;
    settle();
    check("rm_new_gnt", gnt, 1);
    tick(); req = 1'b0; settle();
    check("rm_new_paddr", paddr, 32'h1A10_0300);
    tick(); settle();
    tick(); settle();
    check("rm_new_rvalid", rvalid, 1);
    check("rm_new_rdata", rdata, 32'hA5A5_0001);

`ifdef APB_BRIDGE_TIMEOUT_EN
    // Timeout: 8 ACCESS cycles with pready low
    tick();
    req = 1'b1; addr = 32'h1A10_0400; pready = 1'b0; prdata = 32'hFFFF_FFFF;
    settle();
    tick(); req = 1'b0; settle();
    for (int c = 2; c <= 9; c++) begin
      tick(); settle();
      check("to_acc_penable", penable, 1);
      check("to_acc_rvalid", rvalid, 0);
    end
    tick(); settle();
    check("to_rvalid", rvalid, 1);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
    check("to_psel", psel, 0);
    tick(); settle();
    check("to_idle_rvalid", rvalid, 0);
    check("to_idle_psel", psel, 0);
`endif

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
